mb_tx_multilane_serializer: RTL and testbench
=============================================

# mb_tx_multilane_serializer

Multi-lane mainband TX serializer. Accepts one parallel word per valid/ready handshake, splits it into `NUM_LANES` lane slices of `SER_RATIO` bits, and shifts all lanes out in lockstep, one bit per lane per clock. A one-entry holding buffer allows gapless back-to-back words. `SER_EN` pauses and resumes mid-word without losing bits. It sits between the mainband TX data path (adapter side) and the per-lane analog/PHY bit inputs.

## Interface
Parameters:
- `NUM_LANES`, 16: number of serial lanes; ≥1.
- `SER_RATIO`, 32: bits per lane per word; ≥2, any value (not restricted to powers of two).
- `IDX_W`, `$clog2(SER_RATIO)`: bit-index counter width (derived).

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `CLK`  in  1  serializer clock.
- `RST`  in  1  asynchronous active-low reset.
- `P_DATA`  in  `NUM_LANES*SER_RATIO`  parallel word; lane L slice is `P_DATA[L*SER_RATIO +: SER_RATIO]`.
- `P_VALID`  in  1  `P_DATA` valid.
- `P_READY`  out  1  holding buffer can accept; equals `~HOLD_FULL`, driven directly from a flop.
- `SER_EN`  in  1  emission enable; low pauses serialization.
- `SER_OUT`  out  `NUM_LANES`  registered serial bit per lane.
- `SER_VALID`  out  1  registered; `SER_OUT` carries a real data bit this cycle.
- `BUSY`  out  1  registered; a word is active or the holding buffer is full.

## Operation
- Storage: holding register `HOLD` with flag `HOLD_FULL`; active word register `ACT`; bit index `IDX`, the next bit to emit; state `IDLE` or `SHIFT`.
- Accept: on an edge where `P_VALID & P_READY`, `HOLD <= P_DATA` and `HOLD_FULL <= 1`.
- Bit select: lane L emits `ACT[L*SER_RATIO + IDX]` (LSB first).
- `IDLE`, on an edge with `SER_EN=1 & HOLD_FULL=1`:
  - `ACT <= HOLD` and `HOLD_FULL <= 0`.
  - Each lane emits bit 0 taken directly from `HOLD`.
  - `SER_VALID <= 1`, `IDX <= 1`, go to `SHIFT`.
- `SHIFT`, on an edge with `SER_EN=1`:
  - Emit bit `IDX`, `SER_VALID <= 1`.
  - If `IDX < SER_RATIO-1`: `IDX++`.
  - If `IDX == SER_RATIO-1` (compared explicitly, no reliance on counter wrap), the word is done:
    - With `HOLD_FULL=1`: `ACT <= HOLD`, clear `HOLD_FULL`, `IDX <= 0`, stay in `SHIFT`. Bit 0 of the new word is emitted on the next edge, so there is no gap.
    - Otherwise `IDX <= 0` and go to `IDLE`.
- `SHIFT` with `SER_EN=0`: hold `IDX` and `ACT`; `SER_OUT <= 0`, `SER_VALID <= 0`. On reassertion, resume at the held `IDX`.
- `IDLE` with nothing to send, or with `SER_EN=0`: `SER_OUT <= 0`, `SER_VALID <= 0`.
- Accepting a new word is independent of `SER_EN`.
- An accept and a hold→act transfer never coincide, because a transfer needs `HOLD_FULL=1` and then `P_READY=0`.
- `BUSY <= (next state == SHIFT) | next HOLD_FULL`.

## Timing
- Reset values: `SER_OUT=0`, `SER_VALID=0`, `BUSY=0`, `P_READY=1`, `HOLD_FULL=0`, `IDX=0`, state `IDLE`. `HOLD` and `ACT` are cleared to 0.
- Reset asserted mid-word: immediate return to the reset state. Both the active and the held word are discarded and are never emitted afterwards.
- Latency: word accepted at edge E0 → bit 0 appears on `SER_OUT` after E1, provided `SER_EN=1` at E1.
- Word duration: exactly `SER_RATIO` edges with `SER_EN=1`.
- Sustained throughput: one word per `SER_RATIO` cycles. The holding buffer reopens (`P_READY=1`) on the cycle after each transfer.
- `SER_VALID` low marks every gap and every paused cycle; `SER_OUT` is forced to 0 whenever `SER_VALID=0`.

## Configuration
- `MB_SER_MSB_FIRST_EN` defined: lane L emits `ACT[L*SER_RATIO + SER_RATIO-1-IDX]`, i.e. MSB first. The `IDLE` first bit is taken from `HOLD` at index `SER_RATIO-1`.
- Undefined (default): LSB first, as described in Operation.
- Timing and handshake behaviour are identical in both builds.

## Test plan
All scenarios use `NUM_LANES=4`, `SER_RATIO=8`.
- Reset then single word: `P_DATA=32'hA5C3_0FF0`, `SER_EN=1` → after the accept edge plus 1, lane0 emits 0,0,0,0,1,1,1,1 and lane3 emits 1,0,1,0,0,1,0,1 (LSB first); `SER_VALID` is high for exactly 8 cycles; then `BUSY=0`.
- Back-to-back: present words 32'h0000_00FF and 32'hFFFF_FF00 as soon as `P_READY` allows → 16 consecutive `SER_VALID=1` cycles with no gap; `P_READY` is low only while `HOLD` is full.
- Pause: drop `SER_EN` for 3 cycles after bit 2 of word 32'h1234_5678 → `SER_VALID=0` and `SER_OUT=0` for those 3 cycles; bit 3 follows on resume; 8 data bits total per lane.
- Backpressure: keep `P_VALID=1` with `SER_EN=0` → exactly one word is accepted, then `P_READY=0`; `BUSY=1` and `SER_VALID=0` hold indefinitely.
- Reset mid-word: assert `RST=0` at bit 5 with `HOLD` full → all outputs return to reset values at once; after release, nothing is emitted until a new handshake occurs.
- Build with `MB_SER_MSB_FIRST_EN` and repeat the first scenario → lane0 emits 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/mb_tx_multilane_serializer.sv
// Multi-lane mainband TX serializer: one-entry holding buffer feeding NUM_LANES lockstep shift lanes.
// Define MB_SER_MSB_FIRST_EN to emit each lane slice MSB first (default build is LSB first).
module mb_tx_multilane_serializer #(
    parameter int NUM_LANES = 16,
    parameter int SER_RATIO = 32,
    parameter int IDX_W     = $clog2(SER_RATIO)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_LANES*SER_RATIO-1:0] P_DATA,
    input  logic                           P_VALID,
    output logic                           P_READY,
    input  logic                           SER_EN,
    output logic [NUM_LANES-1:0]           SER_OUT,
    output logic                           SER_VALID,
    output logic                           BUSY
);

    localparam int               WORD_W   = NUM_LANES * SER_RATIO;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SER_RATIO - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // One bit from every lane slice at a given emission index, honouring the bit order of the build.
    function automatic logic [NUM_LANES-1:0] lane_bits(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        logic [NUM_LANES-1:0] bits;
        logic [SER_RATIO-1:0] slice;
        logic [IDX_W-1:0]     pos;
        bits = '0;
`ifdef MB_SER_MSB_FIRST_EN
        pos = LAST_IDX - idx;
`else
        pos = idx;
`endif
        for (int l = 0; l < NUM_LANES; l++) begin
            slice   = word[l*SER_RATIO +: SER_RATIO];
            bits[l] = slice[pos];
        end
        return bits;
    endfunction

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [WORD_W-1:0]    act_q, act_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_LANES-1:0] ser_out_q, ser_out_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 busy_q, busy_d;
    logic                 p_ready_q, p_ready_d;
    logic                 accept_s;

    assign accept_s = P_VALID & p_ready_q;

    // Next-state and registered-output computation for the serializer FSM.
    always_comb begin
        state_d     = state_q;
        hold_d      = accept_s ? P_DATA : hold_q;
        hold_full_d = hold_full_q | accept_s;
        act_d       = act_q;
        idx_d       = idx_q;
        ser_out_d   = '0;
        ser_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // First bit comes straight from HOLD so the word starts on the transfer edge.
                if (SER_EN && hold_full_q) begin
                    act_d       = hold_q;
                    hold_full_d = 1'b0;
                    ser_out_d   = lane_bits(hold_q, '0);
                    ser_valid_d = 1'b1;
                    idx_d       = IDX_W'(1);
                    state_d     = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (SER_EN) begin
                    ser_out_d   = lane_bits(act_q, idx_q);
                    ser_valid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (hold_full_q) begin
                            act_d       = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                hold_full_d = 1'b0;
                idx_d       = '0;
            end
        endcase

        busy_d    = (state_d == ST_SHIFT) | hold_full_d;
        p_ready_d = ~hold_full_d;
    end

    // State, data and output registers; reset discards both the active and the held word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            act_q       <= '0;
            idx_q       <= '0;
            ser_out_q   <= '0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            p_ready_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            act_q       <= act_d;
            idx_q       <= idx_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            p_ready_q   <= p_ready_d;
        end
    end

    assign P_READY   = p_ready_q;
    assign SER_OUT   = ser_out_q;
    assign SER_VALID = ser_valid_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_mb_tx_multilane_serializer.sv
// Directed self-checking bench for mb_tx_multilane_serializer (4 lanes x 8 bits); honours MB_SER_MSB_FIRST_EN.
module tb_mb_tx_multilane_serializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] P_DATA = 32'h0;
    logic        P_VALID = 1'b0;
    logic        P_READY;
    logic        SER_EN = 1'b0;
    logic [3:0]  SER_OUT;
    logic        SER_VALID;
    logic        BUSY;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Per-cycle lane nibbles {lane3,lane2,lane1,lane0} in LSB-first order, hand-derived.
    logic [3:0] tab_a [0:7] = '{4'hE, 4'h6, 4'hA, 4'h2, 4'h1, 4'h9, 4'h5, 4'hD}; // 32'hA5C3_0FF0
    logic [3:0] tab_p [0:7] = '{4'h0, 4'hA, 4'h6, 4'h1, 4'hF, 4'h5, 4'h3, 4'h0}; // 32'h1234_5678

    mb_tx_multilane_serializer #(
        .NUM_LANES (4),
        .SER_RATIO (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .P_VALID   (P_VALID),
        .P_READY   (P_READY),
        .SER_EN    (SER_EN),
        .SER_OUT   (SER_OUT),
        .SER_VALID (SER_VALID),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic int ord(input int k);
`ifdef MB_SER_MSB_FIRST_EN
        return 7 - k;
`else
        return k;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int acc;
        logic pre;
        logic [3:0] exp_out;
        logic exp_v;

        // Reset state
        #12;
        check_val("rst_out", 32'(SER_OUT), 32'h0);
        check_val("rst_valid", 32'(SER_VALID), 32'h0);
        check_val("rst_busy", 32'(BUSY), 32'h0);
        check_val("rst_ready", 32'(P_READY), 32'h1);
        RST = 1'b1;

        // Single word
        P_DATA = 32'hA5C3_0FF0; P_VALID = 1'b1; SER_EN = 1'b1;
        tick();
        check_val("s1_ready_acc", 32'(P_READY), 32'h0);
        check_val("s1_valid_acc", 32'(SER_VALID), 32'h0);
        check_val("s1_busy_acc", 32'(BUSY), 32'h1);
        P_VALID = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("s1_valid%0d", k), 32'(SER_VALID), 32'h1);
            check_val($sformatf("s1_out%0d", k), 32'(SER_OUT), 32'(tab_a[ord(k)]));
            if (k == 0) check_val("s1_ready_reopen", 32'(P_READY), 32'h1);
        end
        tick();
        check_val("s1_valid_end", 32'(SER_VALID), 32'h0);
        check_val("s1_out_end", 32'(SER_OUT), 32'h0);
        check_val("s1_busy_end", 32'(BUSY), 32'h0);

        // Back-to-back words
        P_DATA = 32'h0000_00FF; P_VALID = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (c == 0) P_DATA = 32'hFFFF_FF00;
            if (c == 2) P_VALID = 1'b0;
            exp_v   = (c >= 1 && c <= 16);
            exp_out = (c >= 1 && c <= 8) ? 4'h1 : ((c >= 9 && c <= 16) ? 4'hE : 4'h0);
            check_val($sformatf("b2b_valid%0d", c), 32'(SER_VALID), 32'(exp_v));
            check_val($sformatf("b2b_out%0d", c), 32'(SER_OUT), 32'(exp_out));
            check_val($sformatf("b2b_ready%0d", c), 32'(P_READY), 32'(c == 1 || c >= 8));
        end
        check_val("b2b_busy_end", 32'(BUSY), 32'h0);

        // Pause for 3 cycles after bit 2
        P_DATA = 32'h1234_5678; P_VALID = 1'b1; SER_EN = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c == 0) P_VALID = 1'b0;
            if (c == 3) SER_EN = 1'b0;
            if (c == 6) SER_EN = 1'b1;
            exp_v   = (c >= 1 && c <= 3) || (c >= 7 && c <= 11);
            exp_out = 4'h0;
            if (c >= 1 && c <= 3)  exp_out = tab_p[ord(c - 1)];
            if (c >= 7 && c <= 11) exp_out = tab_p[ord(c - 4)];
            check_val($sformatf("pause_valid%0d", c), 32'(SER_VALID), 32'(exp_v));
            check_val($sformatf("pause_out%0d", c), 32'(SER_OUT), 32'(exp_out));
            check_val($sformatf("pause_busy%0d", c), 32'(BUSY), 32'(c <= 10));
        end

        // Backpressure with SER_EN low: only one word accepted
        SER_EN = 1'b0; P_VALID = 1'b1; P_DATA = 32'hA5C3_0FF0; acc = 0;
        for (int c = 0; c < 10; c++) begin
            pre = P_VALID & P_READY;
            tick();
            if (pre) acc++;
            if (c == 0) P_DATA = 32'h0000_0000;
            check_val($sformatf("bp_ready%0d", c), 32'(P_READY), 32'h0);
            check_val($sformatf("bp_busy%0d", c), 32'(BUSY), 32'h1);
            check_val($sformatf("bp_valid%0d", c), 32'(SER_VALID), 32'h0);
        end
        check_val("bp_accepts", 32'(acc), 32'h1);
        P_VALID = 1'b0; SER_EN = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("bp_dvalid%0d", k), 32'(SER_VALID), 32'(k < 8));
            check_val($sformatf("bp_dout%0d", k), 32'(SER_OUT), (k < 8) ? 32'(tab_a[ord(k)]) : 32'h0);
        end
        check_val("bp_busy_end", 32'(BUSY), 32'h0);

        // Reset mid-word at bit 5 with HOLD full
        P_DATA = 32'hA5C3_0FF0; P_VALID = 1'b1; SER_EN = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) P_DATA = 32'hFFFF_FFFF;
            if (c == 2) P_VALID = 1'b0;
        end
        check_val("mr_bit5", 32'(SER_OUT), 32'(tab_a[ord(5)]));
        check_val("mr_hold_full", 32'(P_READY), 32'h0);
        RST = 1'b0;
        #1;
        check_val("mr_out", 32'(SER_OUT), 32'h0);
        check_val("mr_valid", 32'(SER_VALID), 32'h0);
        check_val("mr_busy", 32'(BUSY), 32'h0);
        check_val("mr_ready", 32'(P_READY), 32'h1);
        tick();
        tick();
        RST = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check_val($sformatf("mr_quiet_valid%0d", c), 32'(SER_VALID), 32'h0);
            check_val($sformatf("mr_quiet_busy%0d", c), 32'(BUSY), 32'h0);
        end
        P_DATA = 32'h0000_00FF; P_VALID = 1'b1;
        tick();
        P_VALID = 1'b0;
        tick();
        check_val("mr_new_valid", 32'(SER_VALID), 32'h1);
        check_val("mr_new_out", 32'(SER_OUT), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
